// File: rtl/multicycle_seq.sv
// ---------------------------------------------------------------------------
// multicycle_seq
//
// Multi-cycle control sequencer for a single-issue MIPS core. One instruction
// at a time is stepped through Fetch / Decode / Execute / Memory / Writeback.
// The sequencer latches the instruction register, waits on instruction and
// data memory handshakes, and enforces a minimum memory-stage latency.
//
// Parameters
//   MEM_WAIT  minimum extra cycles spent in M before dmem_ready is honoured
//             (0..15)
//   CNT_W     width of the performance counters
//
// Ports
//   clk           core clock, rising edge
//   reset         synchronous, active-high
//   instruction   fetched word, valid when imem_ready=1 (sampled only in F)
//   imem_ready    instruction memory has data this cycle
//   dmem_ready    data memory access complete this cycle
//   fetch_en .. writeback_en   one-hot stage enables (Moore, from state flops)
//   wb_src        0 = writeback from ALU, 1 = from memory load
//   ir            latched instruction register
//   retire        one-cycle pulse, first cycle back in F after completion
//   illegal       one-cycle pulse, first cycle back in F after a bad opcode
//   retire_cnt    retired-instruction count
//   stall_cnt     handshake-wait cycle count
//
// Configuration macro
//   MC_PERF_CNT_EN  when defined, retire_cnt / stall_cnt are live counters
//                   (wrapping modulo 2^CNT_W); otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module multicycle_seq #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             wb_src,
  output logic [31:0]      ir,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // One-hot state encoding: each bit is directly a stage enable, so the
  // enables come straight from flops with no decode logic behind them.
  typedef enum logic [4:0] {
    S_F = 5'b00001,
    S_D = 5'b00010,
    S_E = 5'b00100,
    S_M = 5'b01000,
    S_W = 5'b10000
  } state_t;

  typedef enum logic [2:0] {
    C_JMP,
    C_BR,
    C_ST,
    C_LD,
    C_ALU,   // both register and immediate ALU forms
    C_NOP,
    C_BAD
  } iclass_t;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t     state;
  iclass_t    cls;
  logic [3:0] wait_cnt;
  logic       mem_exit;
  logic       retire_set;
  logic       illegal_set;

  function automatic iclass_t decode(input logic [31:0] word);
    iclass_t    c;
    logic [5:0] op;
    logic [5:0] fn;
    op = word[31:26];
    fn = word[5:0];
    case (op)
      6'b000010:                                 c = C_JMP;
      6'b000100, 6'b000101:                      c = C_BR;
      6'b101011:                                 c = C_ST;
      6'b100011:                                 c = C_LD;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: c = C_ALU;
      6'b000000:                                 c = (fn == 6'b000000) ? C_NOP : C_ALU;
      default:                                   c = C_BAD;
    endcase
    return c;
  endfunction

  // Decode always works from the latched ir, never from the live bus, so the
  // instruction bus is free to change once the fetch has completed.
  assign cls = decode(ir);

  // Early dmem_ready is ignored until the minimum latency has elapsed.
  assign mem_exit = (wait_cnt == WAIT_MAX) && dmem_ready;

  assign fetch_en     = state[0];
  assign decode_en    = state[1];
  assign execute_en   = state[2];
  assign memory_en    = state[3];
  assign writeback_en = state[4];

  // Completion / illegal conditions, shared by the pulse flops and counters.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    retire_set  = 1'b0;
    illegal_set = 1'b0;
    case (state)
      S_D: begin
        retire_set  = (cls == C_JMP) || (cls == C_NOP);
        illegal_set = (cls == C_BAD);
      end
      S_E:     retire_set = (cls == C_BR);
      S_M:     retire_set = mem_exit && (cls != C_LD);
      S_W:     retire_set = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= S_F;
      ir       <= '0;
      wb_src   <= 1'b0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      retire  <= retire_set;
      illegal <= illegal_set;
      case (state)
        S_F: begin
          // A zero word is treated as "nothing fetched" and not latched.
          if (imem_ready && (instruction != 32'd0)) begin
            ir    <= instruction;
            state <= S_D;
          end
        end
        S_D: begin
          if (retire_set || illegal_set) state <= S_F;
          else                           state <= S_E;
        end
        S_E: begin
          case (cls)
            C_BR:  state <= S_F;
            C_ALU: begin
              state  <= S_W;
              wb_src <= 1'b0;
            end
            C_ST, C_LD: begin
              state    <= S_M;
              wait_cnt <= '0;
            end
            default: state <= S_F;
          endcase
        end
        S_M: begin
          if (mem_exit) begin
            if (cls == C_LD) begin
              state  <= S_W;
              wb_src <= 1'b1;
            end else begin
              state <= S_F;
            end
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_W:     state <= S_F;
        default: state <= S_F;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic stall_evt;

  assign stall_evt = (fetch_en && !imem_ready) || (memory_en && !mem_exit);

  // Counters bump on the same edge that raises the retire pulse, so the new
  // count is visible alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire_set) retire_cnt <= retire_cnt + CNT_W'(1);
      if (stall_evt)  stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_multicycle_seq
//
// Directed bench for multicycle_seq. Two instances run side by side:
// u_mw0 (MEM_WAIT=0) and u_mw2 (MEM_WAIT=2), sharing clk and reset but with
// their own input buses. Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_multicycle_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  localparam logic [4:0] EF = 5'b10000;
  localparam logic [4:0] ED = 5'b01000;
  localparam logic [4:0] EE = 5'b00100;
  localparam logic [4:0] EM = 5'b00010;
  localparam logic [4:0] EW = 5'b00001;

  logic [31:0] instr0, instr2;
  logic        imem0, imem2, dmem0, dmem2;
  logic        fe0, de0, ee0, me0, we0, wb0, ret0, ill0;
  logic        fe2, de2, ee2, me2, we2, wb2, ret2, ill2;
  logic [31:0] ir0, ir2, rc0, rc2, sc0, sc2;
  logic [4:0]  en0, en2;

  assign en0 = {fe0, de0, ee0, me0, we0};
  assign en2 = {fe2, de2, ee2, me2, we2};

  int total = 0;
  int bad   = 0;

  multicycle_seq #(.MEM_WAIT(0), .CNT_W(32)) u_mw0 (
    .clk(clk), .reset(reset), .instruction(instr0), .imem_ready(imem0),
    .dmem_ready(dmem0), .fetch_en(fe0), .decode_en(de0), .execute_en(ee0),
    .memory_en(me0), .writeback_en(we0), .wb_src(wb0), .ir(ir0),
    .retire(ret0), .illegal(ill0), .retire_cnt(rc0), .stall_cnt(sc0)
  );

  multicycle_seq #(.MEM_WAIT(2), .CNT_W(32)) u_mw2 (
    .clk(clk), .reset(reset), .instruction(instr2), .imem_ready(imem2),
    .dmem_ready(dmem2), .fetch_en(fe2), .decode_en(de2), .execute_en(ee2),
    .memory_en(me2), .writeback_en(we2), .wb_src(wb2), .ir(ir2),
    .retire(ret2), .illegal(ill2), .retire_cnt(rc2), .stall_cnt(sc2)
  );

  // Expected counter value: the live count when counters are built in,
  // otherwise the tied-off zero.
  function automatic logic [31:0] pc(input int v);
`ifdef MC_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    instr0 = 32'd0; instr2 = 32'd0;
    imem0  = 1'b1;  imem2  = 1'b1;
    dmem0  = 1'b0;  dmem2  = 1'b0;
    step();
    step();
    total++; if (en0 !== EF) begin bad++; $display("FAIL reset_en0: got %b want %b", en0, EF); end
    total++; if (en2 !== EF) begin bad++; $display("FAIL reset_en2: got %b want %b", en2, EF); end
    total++; if ({wb0, ret0, ill0, wb2, ret2, ill2} !== 6'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 000000", {wb0, ret0, ill0, wb2, ret2, ill2});
    end
    total++; if (ir0 !== 32'd0 || ir2 !== 32'd0) begin
      bad++; $display("FAIL reset_ir: got %h/%h want 0", ir0, ir2);
    end
    total++; if (rc0 !== 32'd0 || sc0 !== 32'd0 || rc2 !== 32'd0 || sc2 !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", rc0, sc0, rc2, sc2);
    end
    reset = 1'b0;
    // Zero word with imem_ready: nothing is fetched.
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (en0 !== EF || ret0 !== 1'b0) begin
        bad++; $display("FAIL zero_fetch cyc %0d: got en=%b ret=%b want en=%b ret=0", i, en0, ret0, EF);
      end
    end
  endtask

  task automatic test_lw();
    logic [4:0] seq [7];
    seq = '{ED, EE, EM, EM, EM, EW, EF};
    instr2 = 32'h8C22_0004; imem2 = 1'b1; dmem2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) instr2 = 32'd0;
      total++; if (en2 !== seq[i]) begin
        bad++; $display("FAIL lw_state step %0d: got %b want %b", i, en2, seq[i]);
      end
      total++; if (ret2 !== 1'(i == 6)) begin
        bad++; $display("FAIL lw_retire step %0d: got %b want %b", i, ret2, 1'(i == 6));
      end
      if (i == 5) begin
        total++; if (wb2 !== 1'b1) begin bad++; $display("FAIL lw_wb_src: got %b want 1", wb2); end
      end
    end
    total++; if (ir2 !== 32'h8C22_0004) begin bad++; $display("FAIL lw_ir: got %h want 8c220004", ir2); end
    step();
    total++; if (ret2 !== 1'b0) begin bad++; $display("FAIL lw_retire_pulse: got %b want 0", ret2); end
    total++; if (rc2 !== pc(1) || sc2 !== pc(2)) begin
      bad++; $display("FAIL lw_cnt: got rc=%0d sc=%0d want rc=%0d sc=%0d", rc2, sc2, pc(1), pc(2));
    end
  endtask

  task automatic test_alu();
    logic [4:0] seq [4];
    seq = '{ED, EE, EW, EF};
    instr2 = 32'h2001_0005; imem2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) instr2 = 32'd0;
      total++; if (en2 !== seq[i]) begin
        bad++; $display("FAIL alu_state step %0d: got %b want %b", i, en2, seq[i]);
      end
      total++; if (ret2 !== 1'(i == 3)) begin
        bad++; $display("FAIL alu_retire step %0d: got %b want %b", i, ret2, 1'(i == 3));
      end
      // wb_src was left at 1 by the load; E->W must clear it.
      if (i == 2) begin
        total++; if (wb2 !== 1'b0) begin bad++; $display("FAIL alu_wb_src: got %b want 0", wb2); end
      end
    end
    total++; if (ir2 !== 32'h2001_0005) begin bad++; $display("FAIL alu_ir: got %h want 20010005", ir2); end
    step();
    total++; if (rc2 !== pc(2) || sc2 !== pc(2)) begin
      bad++; $display("FAIL alu_cnt: got rc=%0d sc=%0d want rc=%0d sc=%0d", rc2, sc2, pc(2), pc(2));
    end
  endtask

  task automatic test_short_ops();
    logic [31:0] ops  [4];
    int          lens [4];
    logic [4:0]  seqs [4][4];
    ops  = '{32'h0800_0010, 32'h1000_0004, 32'h0000_0040, 32'h0022_1820};
    lens = '{2, 3, 2, 4};
    seqs = '{'{ED, EF, EF, EF}, '{ED, EE, EF, EF}, '{ED, EF, EF, EF}, '{ED, EE, EW, EF}};
    // Instruction memory not ready: stays in F, two stall cycles.
    instr0 = ops[0]; imem0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (en0 !== EF) begin bad++; $display("FAIL imem_stall cyc %0d: got %b want %b", i, en0, EF); end
    end
    imem0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr0 = ops[k];
      for (int i = 0; i < lens[k]; i++) begin
        step();
        if (i == 0) instr0 = 32'd0;
        total++; if (en0 !== seqs[k][i] || ret0 !== 1'(i == lens[k] - 1)) begin
          bad++; $display("FAIL op%0d_seq step %0d: got en=%b ret=%b want en=%b ret=%b",
                          k, i, en0, ret0, seqs[k][i], 1'(i == lens[k] - 1));
        end
      end
      total++; if (ir0 !== ops[k]) begin bad++; $display("FAIL op%0d_ir: got %h want %h", k, ir0, ops[k]); end
    end
    step();
    total++; if (rc0 !== pc(4) || sc0 !== pc(2)) begin
      bad++; $display("FAIL short_cnt: got rc=%0d sc=%0d want rc=%0d sc=%0d", rc0, sc0, pc(4), pc(2));
    end
  endtask

  task automatic test_sw();
    logic [4:0] seq [7];
    seq = '{ED, EE, EM, EM, EM, EM, EF};
    instr0 = 32'hAC22_0004; imem0 = 1'b1; dmem0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      total++; if (en0 !== seq[i] || ret0 !== 1'(i == 6)) begin
        bad++; $display("FAIL sw_seq step %0d: got en=%b ret=%b want en=%b ret=%b",
                        i, en0, ret0, seq[i], 1'(i == 6));
      end
      total++; if (ir0 !== 32'hAC22_0004) begin
        bad++; $display("FAIL sw_ir step %0d: got %h want ac220004", i, ir0);
      end
      // Toggle the bus while busy; after the 4th M cycle is seen, complete.
      if (i < 5) instr0 = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h2001_0005;
      else       instr0 = 32'd0;
      if (i == 5) dmem0 = 1'b1;
    end
    dmem0 = 1'b0;
    step();
    total++; if (rc0 !== pc(5) || sc0 !== pc(5)) begin
      bad++; $display("FAIL sw_cnt: got rc=%0d sc=%0d want rc=%0d sc=%0d", rc0, sc0, pc(5), pc(5));
    end
  endtask

  task automatic test_illegal();
    instr0 = 32'hFC00_0000; imem0 = 1'b1;
    step();
    instr0 = 32'd0;
    total++; if (en0 !== ED || ill0 !== 1'b0) begin
      bad++; $display("FAIL ill_decode: got en=%b ill=%b want en=%b ill=0", en0, ill0, ED);
    end
    step();
    total++; if (en0 !== EF || ill0 !== 1'b1 || ret0 !== 1'b0) begin
      bad++; $display("FAIL ill_pulse: got en=%b ill=%b ret=%b want en=%b ill=1 ret=0", en0, ill0, ret0, EF);
    end
    step();
    total++; if (ill0 !== 1'b0 || ret0 !== 1'b0) begin
      bad++; $display("FAIL ill_clear: got ill=%b ret=%b want 0 0", ill0, ret0);
    end
    total++; if (rc0 !== pc(5)) begin bad++; $display("FAIL ill_cnt: got %0d want %0d", rc0, pc(5)); end
  endtask

  task automatic test_reset_mid();
    // Load parked in M (dmem never ready), then reset.
    instr2 = 32'h8C22_0004; imem2 = 1'b1; dmem2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) instr2 = 32'd0;
    end
    total++; if (en2 !== EM) begin bad++; $display("FAIL mid_in_m: got %b want %b", en2, EM); end
    reset = 1'b1;
    step();
    total++; if (en2 !== EF || ret2 !== 1'b0 || ir2 !== 32'd0 || wb2 !== 1'b0) begin
      bad++; $display("FAIL mid_reset_m: got en=%b ret=%b ir=%h wb=%b want en=%b 0 0 0", en2, ret2, ir2, wb2, EF);
    end
    total++; if (rc2 !== 32'd0 || sc2 !== 32'd0 || rc0 !== 32'd0 || sc0 !== 32'd0) begin
      bad++; $display("FAIL mid_reset_cnt: got %0d %0d %0d %0d want 0", rc2, sc2, rc0, sc0);
    end
    reset = 1'b0;
    // ALU op reaches W, then reset collides with its retire edge.
    instr0 = 32'h2001_0005; imem0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) instr0 = 32'd0;
    end
    total++; if (en0 !== EW) begin bad++; $display("FAIL mid_in_w: got %b want %b", en0, EW); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (en0 !== EF || ret0 !== 1'b0 || rc0 !== 32'd0) begin
      bad++; $display("FAIL mid_reset_w: got en=%b ret=%b rc=%0d want en=%b 0 0", en0, ret0, rc0, EF);
    end
    step();
    total++; if (ret0 !== 1'b0 || en0 !== EF) begin
      bad++; $display("FAIL mid_after: got en=%b ret=%b want en=%b ret=0", en0, ret0, EF);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu();
    test_short_ops();
    test_sw();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
